regfile_mp: RTL

Parametrised multi-port integer register file with a built-in per-register busy scoreboard. Next-generation register file for the core. It serves NR combinational read ports and NW write-back ports, hardwires register 0 to zero, and tracks pending destination registers for the issue stage's hazard checks. It sits between decode/issue (reads, allocation) and write-back (writes, busy release).

---
 rtl/regfile_mp_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 52 +++++
 rtl/regfile_mp.sv | 95 +++++++++
 3 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared core types and register-file defaults.
//   data_t     : 64-bit integer register value (default XLEN=64 core)
//   reg_ind_t  : 5-bit architectural register index (default DEPTH=32 core)
//   REGFILE_NR : default number of read ports
//   REGFILE_NW : default number of write-back ports
// No ports; imported by regfile_mp and regfile_scoreboard.
package regfile_mp_pkg;

  typedef logic [63:0] data_t;
  typedef logic [4:0]  reg_ind_t;

  localparam int REGFILE_NR = 2;
  localparam int REGFILE_NW = 1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for the issue stage's hazard checks.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   wr_en/wr_addr       : NW write-back ports; a write releases its destination
//   alloc_en/alloc_addr : issue-time allocation; marks the destination busy
//   flush               : clears every busy bit (priority over alloc)
//   busy                : DEPTH-bit registered busy vector, bit 0 always 0
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int NW    = REGFILE_NW,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic             alloc_en,
  input  logic [AW-1:0]    alloc_addr,
  input  logic             flush,
  output logic [DEPTH-1:0] busy
);

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;

  // Order matters: release first, then alloc (alloc beats a same-cycle
  // release), then flush (flush beats alloc).
  always_comb begin
    busy_next = busy_reg;
    for (int p = 0; p < NW; p++) begin
      if (wr_en[p] && (wr_addr[p*AW +: AW] != '0))
        busy_next[wr_addr[p*AW +: AW]] = 1'b0;
    end
    if (alloc_en && (alloc_addr != '0))
      busy_next[alloc_addr] = 1'b1;
    if (flush)
      busy_next = '0;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      busy_reg <= '0;
    else
      busy_reg <= busy_next;
  end

  assign busy = busy_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with built-in busy scoreboard.
// Register 0 reads as zero and ignores writes; registers 1..DEPTH-1 are
// flops so that synchronous reset can clear every entry.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   rd_addr/rd_data     : NR combinational read ports
//   rd_busy             : registered busy bit of each read address
//   wr_en/wr_addr/wr_data : NW write ports, highest port wins on conflict
//   alloc_en/alloc_addr : mark a destination busy
//   flush               : clear all busy bits, data unaffected
// Configuration macro: REGFILE_BYPASS_EN enables same-cycle write-to-read
// forwarding on rd_data (never on rd_busy).
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 32,
  parameter int NR    = REGFILE_NR,
  parameter int NW    = REGFILE_NW,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NR*AW-1:0]   rd_addr,
  output logic [NR*XLEN-1:0] rd_data,
  output logic [NR-1:0]      rd_busy,
  input  logic [NW-1:0]      wr_en,
  input  logic [NW*AW-1:0]   wr_addr,
  input  logic [NW*XLEN-1:0] wr_data,
  input  logic               alloc_en,
  input  logic [AW-1:0]      alloc_addr,
  input  logic               flush
);

  logic [XLEN-1:0]  mem_reg [1:DEPTH-1];
  logic [DEPTH-1:0] busy;

  // Later loop iterations override earlier ones, so the highest-numbered
  // port wins a same-address conflict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++)
        mem_reg[i] <= '0;
    end else begin
      for (int p = 0; p < NW; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] != '0))
          mem_reg[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .NW    (NW),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy       (busy)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] val;

      assign addr = rd_addr[gi*AW +: AW];

      always_comb begin
        val = '0;
        if (addr != '0)
          val = mem_reg[addr];
`ifdef REGFILE_BYPASS_EN
        // Forward in-flight write data; ascending scan keeps highest port.
        if (rst_n && (addr != '0)) begin
          for (int p = 0; p < NW; p++) begin
            if (wr_en[p] && (wr_addr[p*AW +: AW] == addr))
              val = wr_data[p*XLEN +: XLEN];
          end
        end
`endif
      end

      assign rd_data[gi*XLEN +: XLEN] = val;
      assign rd_busy[gi]              = busy[addr];
    end
  endgenerate

endmodule
